// File: rtl/render_pkg.sv
// ---------------------------------------------------------------------------
// render_pkg
// Shared definitions for the triangle feeder and the rasterizer.
//   COORD_W      : width of one coordinate value
//   Z, Y, X      : coordinate indices into a triangle ([coord][vertex])
//   vertex_t     : the three per-vertex values of one coordinate
//   triangle_t   : a full triangle, indexed [coord][vertex]
//   feed_state_t : feeder state encoding
//   tri_value    : source of the triangle table held in the feeder ROM
// ---------------------------------------------------------------------------
package render_pkg;

    localparam int COORD_W = 9;

    localparam int Z = 0;
    localparam int Y = 1;
    localparam int X = 2;

    // One coordinate (z, y or x) for each of the three vertices.
    typedef logic [2:0][COORD_W-1:0] vertex_t;

    // triangle[coord][vertex]; coord 0=z, 1=y, 2=x.
    typedef vertex_t [2:0] triangle_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        SEND      = 3'd3,
        WAIT_RAST = 3'd4,
        DONE      = 3'd5
    } feed_state_t;

    // Triangle table: coordinate c of vertex v of triangle t. Every value is
    // distinct within a table of up to 16 triangles, so any mis-addressed
    // or mis-packed word is visible on the rasterizer side.
    function automatic int tri_value(input int t, input int c, input int v);
        return (t * 16) + (c * 4) + v + 1;
    endfunction

endpackage

// File: rtl/tri_rom.sv
// ---------------------------------------------------------------------------
// tri_rom
// Single-port read-only triangle memory with a fixed read latency.
// One word per triangle, 9*COORD_W bits, packed [coord][vertex] so that
// element (c, v) occupies bits (c*3+v)*COORD_W +: COORD_W.
//   clk_in : clock
//   en     : capture the word at addr into the first pipeline stage
//   addr   : triangle index
//   data   : word read ROM_LATENCY clock edges after the en/addr edge
// ---------------------------------------------------------------------------
module tri_rom
    import render_pkg::*;
#(
    parameter int NUM_TRI     = 12,
    parameter int COORD_W     = 9,
    parameter int ROM_LATENCY = 2,
    parameter int ADDR_W      = 4
) (
    input  logic                   clk_in,
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [9*COORD_W-1:0]   data
);

    logic [9*COORD_W-1:0] mem [NUM_TRI];
    logic [9*COORD_W-1:0] pipe_reg [ROM_LATENCY];

    function automatic logic [9*COORD_W-1:0] build_word(input int t);
        logic [9*COORD_W-1:0] word;
        word = '0;
        for (int v = 0; v < 3; v++) begin
            word[(Z * 3 + v) * COORD_W +: COORD_W] = COORD_W'(tri_value(t, Z, v));
            word[(Y * 3 + v) * COORD_W +: COORD_W] = COORD_W'(tri_value(t, Y, v));
            word[(X * 3 + v) * COORD_W +: COORD_W] = COORD_W'(tri_value(t, X, v));
        end
        return word;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRI; gi++) begin : g_mem
            assign mem[gi] = build_word(gi);
        end
    endgenerate

    // The array read is registered; further stages pad out to ROM_LATENCY.
    // No reset on the data path so it maps onto the block-RAM output regs.
    always_ff @(posedge clk_in) begin
        if (en) begin
            pipe_reg[0] <= mem[addr];
        end
    end

    generate
        for (gi = 1; gi < ROM_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk_in) begin
                pipe_reg[gi] <= pipe_reg[gi-1];
            end
        end
    endgenerate

    assign data = pipe_reg[ROM_LATENCY-1];

endmodule

// File: rtl/tri_feeder.sv
// ---------------------------------------------------------------------------
// tri_feeder
// Walks the triangle ROM once per display frame and hands each triangle to
// the rasterizer with a valid/ready style handshake.
//   clk_in        : system clock
//   rst_in        : asynchronous active-high reset
//   enable_in     : frame generation permitted
//   vsync_in      : one-cycle frame-boundary pulse
//   rast_ready_in : rasterizer is in its receive state
//   new_frame     : one-cycle pulse at frame start (buffer select toggle)
//   valid_tri     : one-cycle pulse, triangle offered and accepted
//   tri_out       : current triangle, [coord][vertex], coord 0=z 1=y 2=x
//   obj_done      : one-cycle pulse after the last triangle completes
//   overrun       : sticky, a frame boundary arrived mid-frame
//   frame_count   : started frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module tri_feeder
    import render_pkg::*;
#(
    parameter int NUM_TRI     = 12,
    parameter int COORD_W     = render_pkg::COORD_W,
    parameter int ROM_LATENCY = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            enable_in,
    input  logic                            vsync_in,
    input  logic                            rast_ready_in,
    output logic                            new_frame,
    output logic                            valid_tri,
    output logic [2:0][2:0][COORD_W-1:0]    tri_out,
    output logic                            obj_done,
    output logic                            overrun,
    output logic [7:0]                      frame_count
);

    localparam int IDX_W = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;
    localparam int CNT_W = $clog2(ROM_LATENCY + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRI - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ROM_LATENCY - 1);

    feed_state_t                    state_reg, state_next;
    logic [IDX_W-1:0]               tri_idx_reg, tri_idx_next;
    logic [CNT_W-1:0]               lat_cnt_reg, lat_cnt_next;
    logic [2:0][2:0][COORD_W-1:0]   tri_out_reg, tri_out_next;
    logic                           new_frame_reg, new_frame_next;
    logic                           overrun_reg, overrun_next;
    logic [7:0]                     frame_count_reg, frame_count_next;
    logic                           skip_reg, skip_next;

    logic                           rom_en;
    logic [9*COORD_W-1:0]           rom_data;
    logic                           valid_tri_int;
    logic                           obj_done_int;

    tri_rom #(
        .NUM_TRI     (NUM_TRI),
        .COORD_W     (COORD_W),
        .ROM_LATENCY (ROM_LATENCY),
        .ADDR_W      (IDX_W)
    ) u_tri_rom (
        .clk_in (clk_in),
        .en     (rom_en),
        .addr   (tri_idx_reg),
        .data   (rom_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg       <= IDLE;
            tri_idx_reg     <= '0;
            lat_cnt_reg     <= '0;
            tri_out_reg     <= '0;
            new_frame_reg   <= 1'b0;
            overrun_reg     <= 1'b0;
            frame_count_reg <= 8'd0;
            skip_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tri_idx_reg     <= tri_idx_next;
            lat_cnt_reg     <= lat_cnt_next;
            tri_out_reg     <= tri_out_next;
            new_frame_reg   <= new_frame_next;
            overrun_reg     <= overrun_next;
            frame_count_reg <= frame_count_next;
            skip_reg        <= skip_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        tri_idx_next     = tri_idx_reg;
        lat_cnt_next     = lat_cnt_reg;
        tri_out_next     = tri_out_reg;
        new_frame_next   = 1'b0;
        overrun_next     = overrun_reg;
        frame_count_next = frame_count_reg;
        skip_next        = skip_reg;
        rom_en           = 1'b0;
        valid_tri_int    = 1'b0;
        obj_done_int     = 1'b0;

        // A frame boundary anywhere but IDLE (DONE included) means the
        // frame did not fit; flag it and let the current frame finish.
        if (vsync_in && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (vsync_in && enable_in) begin
                    new_frame_next   = 1'b1;
                    tri_idx_next     = '0;
                    frame_count_next = frame_count_reg + 8'd1;
                    state_next       = FETCH;
                end
            end

            FETCH: begin
                rom_en       = 1'b1;
                lat_cnt_next = '0;
                state_next   = WAIT_DATA;
            end

            WAIT_DATA: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    tri_out_next = rom_data;
                    state_next   = SEND;
                end else begin
                    lat_cnt_next = lat_cnt_reg + CNT_W'(1);
                end
            end

            SEND: begin
                if (rast_ready_in) begin
                    valid_tri_int = 1'b1;
                    skip_next     = 1'b1;
                    state_next    = WAIT_RAST;
                end
            end

            WAIT_RAST: begin
                // The rasterizer still shows ready in the cycle after it
                // accepts, so that first cycle says nothing about readiness.
                if (skip_reg) begin
                    skip_next = 1'b0;
                end else if (rast_ready_in) begin
                    if (tri_idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        tri_idx_next = tri_idx_reg + IDX_W'(1);
                        state_next   = FETCH;
                    end
                end
            end

            DONE: begin
                obj_done_int = 1'b1;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // valid_tri and obj_done decode directly from the state, so they are low
    // as soon as reset forces IDLE; new_frame is registered and only ever
    // high in the first FETCH cycle, keeping all three pulses disjoint.
    assign new_frame   = new_frame_reg;
    assign valid_tri   = valid_tri_int;
    assign obj_done    = obj_done_int;
    assign tri_out     = tri_out_reg;
    assign overrun     = overrun_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_tri_feeder.sv
// ---------------------------------------------------------------------------
// tb_tri_feeder
// Directed bench for tri_feeder (NUM_TRI=3, ROM_LATENCY=2) with a
// rasterizer stub that stays ready for one cycle after an acceptance and
// then goes busy for 10 cycles. A frame-level model checks every cycle.
// ---------------------------------------------------------------------------
module tb_tri_feeder;

    localparam int NUM_TRI     = 3;
    localparam int COORD_W     = 9;
    localparam int ROM_LATENCY = 2;
    localparam int BUSY_CYC    = 10;

    typedef logic [2:0][2:0][COORD_W-1:0] tri_t;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       enable_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       rast_ready_in;
    logic       new_frame;
    logic       valid_tri;
    tri_t       tri_out;
    logic       obj_done;
    logic       overrun;
    logic [7:0] frame_count;

    tri_feeder #(
        .NUM_TRI     (NUM_TRI),
        .COORD_W     (COORD_W),
        .ROM_LATENCY (ROM_LATENCY)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .enable_in     (enable_in),
        .vsync_in      (vsync_in),
        .rast_ready_in (rast_ready_in),
        .new_frame     (new_frame),
        .valid_tri     (valid_tri),
        .tri_out       (tri_out),
        .obj_done      (obj_done),
        .overrun       (overrun),
        .frame_count   (frame_count)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Rasterizer stub.
    logic hold_low = 1'b0;
    logic stub_lag = 1'b0;
    int   stub_busy = 0;
    always @(posedge clk_in) begin
        if (rst_in) begin
            stub_lag  <= 1'b0;
            stub_busy <= 0;
        end else if (valid_tri) begin
            stub_lag <= 1'b1;
        end else if (stub_lag) begin
            stub_lag  <= 1'b0;
            stub_busy <= BUSY_CYC;
        end else if (stub_busy > 0) begin
            stub_busy <= stub_busy - 1;
        end
    end
    assign rast_ready_in = !hold_low && (stub_busy == 0);

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tri_t exp_tri(input int t);
        tri_t r;
        for (int c = 0; c < 3; c++)
            for (int v = 0; v < 3; v++)
                r[c][v] = COORD_W'(t * 16 + c * 4 + v + 1);
        return r;
    endfunction

    // Frame-level model: a frame starts on vsync while no frame is active
    // and enabled; it delivers NUM_TRI triangles in ROM order and ends with
    // obj_done. Any vsync during an active frame sets overrun.
    bit         m_active = 0;
    int         m_tri = 0;
    logic [7:0] m_fc = 8'd0;
    bit         m_ov = 0;
    bit         exp_nf = 0;
    bit         quiet = 0;
    int         n_nf = 0, n_valid = 0, n_done = 0;
    int         nf_cyc = 0, done_cyc = 0;
    int         valid_cyc[$];
    tri_t       cap [NUM_TRI];

    always @(negedge clk_in) begin
        bit nf_n;
        if (rst_in) begin
            m_active = 0;
            m_tri    = 0;
            m_fc     = 8'd0;
            m_ov     = 0;
            exp_nf   = 0;
        end else begin
            check_eq("new_frame", new_frame, exp_nf);
            check_eq("frame_count", frame_count, m_fc);
            check_eq("overrun", overrun, m_ov);
            check_eq("exclusive_pulses", 96'((32'(new_frame) + 32'(valid_tri) + 32'(obj_done)) <= 1), 96'd1);
            if (valid_tri) begin
                check_eq("valid_needs_ready", rast_ready_in, 1'b1);
                check_eq("valid_in_frame", 96'(m_active && m_tri < NUM_TRI), 96'd1);
                check_eq("tri_out", tri_out, exp_tri(m_tri));
                if (!quiet)
                    $display("tri frame=%0d idx=%0d tri_out=%h cyc=%0d", m_fc, m_tri, tri_out, cyc);
                if (m_tri < NUM_TRI) cap[m_tri] = tri_out;
                m_tri++;
                n_valid++;
                valid_cyc.push_back(cyc);
            end
            if (obj_done) begin
                check_eq("done_after_all_tris", 96'(m_active && m_tri == NUM_TRI), 96'd1);
                n_done++;
                done_cyc = cyc;
            end
            if (new_frame) begin
                n_nf++;
                nf_cyc = cyc;
            end
            nf_n = 0;
            if (vsync_in) begin
                if (!m_active && enable_in) begin
                    nf_n     = 1;
                    m_active = 1;
                    m_fc     = m_fc + 8'd1;
                    m_tri    = 0;
                end else if (m_active) begin
                    m_ov = 1;
                end
            end
            if (obj_done) m_active = 0;
            exp_nf = nf_n;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_vsync();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
    endtask

    task automatic apply_reset();
        vsync_in = 1'b0;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int  start;
        bit  seen;
        start = n_done;
        seen  = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (n_done != start) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: no obj_done within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic wait_valid(input string name, input int target, input int max_cyc);
        bit seen;
        seen = (n_valid >= target);
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick();
            if (n_valid >= target) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: valid_tri count %0d not reached within %0d cycles", name, target, max_cyc);
        end
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   b_nf, b_valid, b_done;
        tri_t snap;
        bit   seen;

        // Reset state.
        tick();
        tick();
        check_eq("rst_new_frame", new_frame, 1'b0);
        check_eq("rst_valid_tri", valid_tri, 1'b0);
        check_eq("rst_obj_done", obj_done, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_frame_count", frame_count, 8'd0);
        check_eq("rst_tri_out", tri_out, '0);
        rst_in = 1'b0;
        tick();

        // One full frame with the stub handshaking.
        enable_in = 1'b1;
        valid_cyc.delete();
        b_nf = n_nf; b_valid = n_valid; b_done = n_done;
        pulse_vsync();
        wait_done("frame1", 200);
        check_eq("f1_new_frames", n_nf - b_nf, 1);
        check_eq("f1_valid_count", n_valid - b_valid, NUM_TRI);
        check_eq("f1_done_count", n_done - b_done, 1);
        check_eq("f1_frame_count", frame_count, 8'd1);
        if (valid_cyc.size() == 3) begin
            check_eq("f1_nf_to_tri0", valid_cyc[0] - nf_cyc, 3);
            check_eq("f1_tri0_to_tri1", valid_cyc[1] - valid_cyc[0], 16);
            check_eq("f1_tri1_to_tri2", valid_cyc[2] - valid_cyc[1], 16);
            check_eq("f1_tri2_to_done", done_cyc - valid_cyc[2], 13);
        end else begin
            check_eq("f1_valid_queue", valid_cyc.size(), 3);
        end
        check_eq("f1_t0_x_v0", cap[0][2][0], 9'd9);
        check_eq("f1_t1_y_v2", cap[1][1][2], 9'd23);
        check_eq("f1_t2_z_v1", cap[2][0][1], 9'd34);
        b_valid = n_valid;
        repeat (20) tick();
        check_eq("f1_idle_after", n_valid - b_valid, 0);

        // Rasterizer never ready for 50 cycles while a triangle waits.
        hold_low = 1'b1;
        b_valid = n_valid; b_done = n_done;
        pulse_vsync();
        repeat (5) tick();
        snap = tri_out;
        repeat (50) tick();
        check_eq("hold_no_valid", n_valid - b_valid, 0);
        check_eq("hold_tri_stable", tri_out, snap);
        check_eq("hold_tri_word0", snap, exp_tri(0));
        check_eq("hold_tri_z_v0", snap[0][0], 9'd1);
        hold_low = 1'b0;
        #1;
        check_eq("ready_rise_valid", valid_tri, 1'b1);
        wait_done("hold_frame", 200);
        check_eq("hold_valid_count", n_valid - b_valid, NUM_TRI);
        check_eq("hold_frame_count", frame_count, 8'd2);

        // vsync arriving during triangle 1.
        apply_reset();
        b_nf = n_nf; b_valid = n_valid; b_done = n_done;
        pulse_vsync();
        wait_valid("ovr_first_tri", b_valid + 1, 100);
        repeat (12) tick();
        pulse_vsync();
        check_eq("ovr_set", overrun, 1'b1);
        wait_done("ovr_frame", 200);
        check_eq("ovr_new_frames", n_nf - b_nf, 1);
        check_eq("ovr_valid_count", n_valid - b_valid, NUM_TRI);
        check_eq("ovr_done_count", n_done - b_done, 1);
        pulse_vsync();
        wait_done("ovr_next_frame", 200);
        check_eq("ovr_next_started", n_nf - b_nf, 2);
        check_eq("ovr_frame_count", frame_count, 8'd2);
        check_eq("ovr_sticky", overrun, 1'b1);

        // vsync coinciding with the DONE cycle.
        apply_reset();
        b_nf = n_nf;
        pulse_vsync();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (obj_done) seen = 1;
        end
        check_eq("done_reached", seen, 1'b1);
        pulse_vsync();
        check_eq("done_vsync_overrun", overrun, 1'b1);
        repeat (20) tick();
        check_eq("done_vsync_no_frame", n_nf - b_nf, 1);
        check_eq("done_vsync_count", frame_count, 8'd1);
        pulse_vsync();
        wait_done("done_next_frame", 200);
        check_eq("done_next_count", frame_count, 8'd2);

        // enable low ignores vsync; enable dropping mid-frame is harmless.
        apply_reset();
        enable_in = 1'b0;
        b_nf = n_nf; b_valid = n_valid; b_done = n_done;
        for (int i = 0; i < 3; i++) begin
            pulse_vsync();
            repeat (5) tick();
        end
        repeat (20) tick();
        check_eq("dis_no_new_frame", n_nf - b_nf, 0);
        check_eq("dis_no_valid", n_valid - b_valid, 0);
        check_eq("dis_no_done", n_done - b_done, 0);
        check_eq("dis_frame_count", frame_count, 8'd0);
        enable_in = 1'b1;
        pulse_vsync();
        wait_valid("dis_first_tri", b_valid + 1, 100);
        enable_in = 1'b0;
        wait_done("dis_frame", 200);
        check_eq("dis_valid_count", n_valid - b_valid, NUM_TRI);
        check_eq("dis_done_count", n_done - b_done, 1);

        // Reset during WAIT_RAST abandons the frame.
        enable_in = 1'b1;
        b_valid = n_valid;
        pulse_vsync();
        wait_valid("rst_mid_tri", b_valid + 1, 100);
        repeat (3) tick();
        #2;
        rst_in = 1'b1;
        #1;
        check_eq("arst_new_frame", new_frame, 1'b0);
        check_eq("arst_valid_tri", valid_tri, 1'b0);
        check_eq("arst_obj_done", obj_done, 1'b0);
        check_eq("arst_overrun", overrun, 1'b0);
        check_eq("arst_frame_count", frame_count, 8'd0);
        check_eq("arst_tri_out", tri_out, '0);
        tick();
        rst_in = 1'b0;
        b_done = n_done; b_nf = n_nf;
        repeat (40) tick();
        check_eq("arst_no_done", n_done - b_done, 0);
        check_eq("arst_no_restart", n_nf - b_nf, 0);
        b_valid = n_valid;
        pulse_vsync();
        wait_valid("arst_restart", b_valid + 1, 100);
        check_eq("arst_restart_tri0", cap[0], exp_tri(0));
        wait_done("arst_frame", 200);

        // frame_count wrap.
        apply_reset();
        quiet = 1;
        for (int f = 0; f < 255; f++) begin
            pulse_vsync();
            wait_done("wrap_frames", 200);
        end
        check_eq("wrap_count_255", frame_count, 8'd255);
        pulse_vsync();
        wait_done("wrap_last", 200);
        check_eq("wrap_count_0", frame_count, 8'd0);
        quiet = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tri_feeder.md
TRI_FEEDER -- requirements
Module: tri_feeder

Interface
REQ-001 The block SHALL have these parameters: NUM_TRI, 12, triangles per frame; COORD_W, 9, coordinate width; ROM_LATENCY, 2, triangle-ROM read latency in cycles.
REQ-002 The block SHALL have these ports: clk_in  input  1  system clock. The block has one clock.
REQ-003 rst_in  input  1  reset; asynchronous, active-high.
REQ-004 enable_in  input  1  frame generation permitted.
REQ-005 vsync_in  input  1  one-cycle frame-boundary pulse from the display timing.
REQ-006 rast_ready_in  input  1  high while the rasterizer is in its receive state.
REQ-007 new_frame  output  1  one-cycle pulse; toggles the rasterizer buffer select.
REQ-008 valid_tri  output  1  one-cycle pulse; triangle offered and accepted.
REQ-009 tri_out  output  [2:0][2:0][COORD_W-1:0]  triangle indexed [coord][vertex]; coord 0=z, 1=y, 2=x.
REQ-010 obj_done  output  1  one-cycle pulse after the last triangle of a frame completes.
REQ-011 overrun  output  1  sticky flag: a frame boundary arrived before the frame finished.
REQ-012 frame_count  output  8  count of started frames; wraps at 255 to 0.

Function
REQ-013 The state machine SHALL have the states IDLE, FETCH, WAIT_DATA, SEND, WAIT_RAST and DONE.
REQ-014 IDLE: when vsync_in=1 and enable_in=1, the block SHALL pulse new_frame for one cycle, set tri_idx to 0, increment frame_count, and go to FETCH.
REQ-015 FETCH: the block SHALL drive the ROM address with tri_idx, clear the latency counter, and go to WAIT_DATA.
REQ-016 WAIT_DATA: the block SHALL count ROM_LATENCY cycles, then register the ROM word into tri_out and go to SEND.
REQ-017 SEND: valid_tri SHALL be asserted only in a cycle with rast_ready_in=1; that cycle is the acceptance, and the next state is WAIT_RAST.
REQ-018 WAIT_RAST: the block SHALL ignore rast_ready_in in the first cycle after acceptance (the rasterizer leaves receive one cycle late), then wait for rast_ready_in=1.
REQ-019 On leaving WAIT_RAST, the block SHALL go to DONE if tri_idx==NUM_TRI-1; otherwise it SHALL increment tri_idx and go to FETCH.
REQ-020 DONE: the block SHALL pulse obj_done for one cycle and return to IDLE.
REQ-021 tri_out SHALL hold its value from the WAIT_DATA latch until the next latch; it SHALL NOT change while valid_tri is high.
REQ-022 valid_tri, new_frame and obj_done SHALL never be high in the same cycle.
REQ-023 If vsync_in=1 in any state other than IDLE, the block SHALL set overrun, SHALL NOT pulse new_frame, and the current frame SHALL continue.
REQ-024 overrun SHALL clear only on reset.
REQ-025 If vsync_in=1 in IDLE with enable_in=0, the block SHALL ignore it.
REQ-026 If enable_in drops mid-frame, the current frame SHALL complete.
REQ-027 If vsync_in and the DONE transition coincide, the block SHALL flag overrun and not start a new frame; the frame starts on the next vsync_in.
REQ-028 tri_idx SHALL be $clog2(NUM_TRI) bits wide and SHALL never exceed NUM_TRI-1.

Reset
REQ-029 While rst_in=1, asynchronously: state=IDLE, tri_idx=0, latency counter=0, tri_out=0, new_frame=0, valid_tri=0, obj_done=0, overrun=0, frame_count=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no obj_done pulse; after release the block SHALL wait in IDLE for vsync_in.

Structure
REQ-031 A shared package render_pkg SHALL hold COORD_W, the vertex_t and triangle_t typedefs ([coord][vertex] order), and the coordinate-index constants Z=0, Y=1, X=2, for reuse by the rasterizer.
REQ-032 A single sub-module tri_rom SHALL wrap the single-port BRAM that holds NUM_TRI triangle words of 9*COORD_W bits, initialised from a file, with ROM_LATENCY read latency.

Verification
Bench settings: NUM_TRI=3, ROM_LATENCY=2, rast_ready_in modelled by a stub that goes busy for 10 cycles after each acceptance.
REQ-033 Reset, enable=1, one vsync pulse -> one new_frame pulse, frame_count=1, exactly 3 valid_tri pulses with ROM words 0, 1, 2 on tri_out, then one obj_done pulse, then IDLE.
REQ-034 rast_ready_in held 0 for 50 cycles while in SEND -> valid_tri stays 0 and tri_out is stable; valid_tri fires the cycle rast_ready_in rises.
REQ-035 Second vsync pulse arrives during triangle 1 -> overrun=1, no new_frame, the frame still emits 3 triangles and obj_done; the next vsync starts frame 2.
REQ-036 enable=0 with vsync pulses -> no outputs; enable drops after the first valid_tri -> the frame still completes with 3 triangles.
REQ-037 rst_in pulsed during WAIT_RAST -> all outputs 0 asynchronously and no obj_done; the next vsync restarts at triangle 0.
REQ-038 Preload frame_count=255 by running 255 frames, then one more frame -> frame_count=0.
